// File: rtl/init_reset_sequencer.sv
// Staged reset sequencer: after POR, device init and a settled PLL lock it releases fabric, then peripheral, then CPU resets.
// Outputs are registered and move on the same edge as STATE; async inputs add SYNC_STAGES cycles; there is no backpressure.
module init_reset_sequencer #(
   parameter int SYNC_STAGES    = 2,
   parameter int SETTLE_CYCLES  = 16,
   parameter int STAGE_DELAY    = 8,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter bit REQUIRE_SRAM   = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       FABRIC_POR_N,
   input  logic       DEVICE_INIT_DONE,
   input  logic       SRAM_INIT_DONE,
   input  logic       USRAM_INIT_DONE,
   input  logic       PLL_LOCK,
   input  logic       EXT_RST_N,
   output logic       FABRIC_RESET_N,
   output logic       PERIPH_RESET_N,
   output logic       CPU_RESET_N,
   output logic       INIT_DONE,
   output logic       TIMEOUT_ERR,
   output logic [2:0] STATE
);

   typedef struct packed {
      logic por_n;
      logic dev_done;
      logic sram_done;
      logic usram_done;
      logic pll_lock;
      logic ext_rst_n;
   } async_in_t;

   typedef enum logic [2:0] {
      WAIT_POR   = 3'd0,
      WAIT_INIT  = 3'd1,
      WAIT_LOCK  = 3'd2,
      REL_FABRIC = 3'd3,
      REL_PERIPH = 3'd4,
      REL_CPU    = 3'd5,
      RUN        = 3'd6,
      ERROR      = 3'd7
   } state_t;

   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] STAGE_LAST   = 16'(STAGE_DELAY - 1);

   async_in_t                   raw;
   async_in_t [SYNC_STAGES-1:0] sync_q;
   async_in_t                   in_s;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic [15:0] cnt_nxt;
   logic [15:0] lk;
   logic [15:0] lk_nxt;
   logic        init_ok;
   logic        link_lost;

   assign raw = {FABRIC_POR_N, DEVICE_INIT_DONE, SRAM_INIT_DONE,
                 USRAM_INIT_DONE, PLL_LOCK, EXT_RST_N};

   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   assign in_s      = sync_q[SYNC_STAGES-1];
   assign init_ok   = in_s.dev_done && (!REQUIRE_SRAM || (in_s.sram_done && in_s.usram_done));
   assign link_lost = !in_s.ext_rst_n || !in_s.pll_lock;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      lk_nxt    = '0;
      case (state)
         WAIT_POR: begin
            if (in_s.por_n) state_nxt = WAIT_INIT;
         end
         WAIT_INIT: begin
            cnt_nxt = cnt + 16'd1;
            if (init_ok) begin
               state_nxt = WAIT_LOCK;
            end else if (cnt == TIMEOUT_LAST) begin
               state_nxt = ERROR;
            end
         end
         WAIT_LOCK: begin
            // An external reset request freezes the timeout and restarts the lock settle window.
            if (!in_s.ext_rst_n) begin
               cnt_nxt = cnt;
            end else begin
               cnt_nxt = cnt + 16'd1;
               if (in_s.pll_lock && lk == SETTLE_LAST) begin
                  state_nxt = REL_FABRIC;
               end else begin
                  if (in_s.pll_lock) lk_nxt = lk + 16'd1;
                  if (cnt == TIMEOUT_LAST) state_nxt = ERROR;
               end
            end
         end
         REL_FABRIC: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt == STAGE_LAST) state_nxt = REL_PERIPH;
         end
         REL_PERIPH: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt == STAGE_LAST) state_nxt = REL_CPU;
         end
         REL_CPU: begin
            cnt_nxt = cnt + 16'd1;
            if (cnt == STAGE_LAST) state_nxt = RUN;
         end
         RUN: begin
            state_nxt = RUN;
         end
         ERROR: begin
            if (!in_s.por_n) state_nxt = WAIT_POR;
         end
         default: begin
            state_nxt = WAIT_POR;
         end
      endcase

      // Aborts override any progress condition evaluated on the same cycle.
      if (state != WAIT_POR && state != ERROR) begin
         if (!in_s.por_n) begin
            state_nxt = WAIT_POR;
         end else if (state >= REL_FABRIC && link_lost) begin
            state_nxt = WAIT_LOCK;
         end
      end

      if (state_nxt != state) begin
         cnt_nxt = '0;
         lk_nxt  = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state          <= WAIT_POR;
         cnt            <= '0;
         lk             <= '0;
         FABRIC_RESET_N <= 1'b0;
         PERIPH_RESET_N <= 1'b0;
         CPU_RESET_N    <= 1'b0;
         INIT_DONE      <= 1'b0;
         TIMEOUT_ERR    <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         lk             <= lk_nxt;
         FABRIC_RESET_N <= state_nxt inside {REL_FABRIC, REL_PERIPH, REL_CPU, RUN};
         PERIPH_RESET_N <= state_nxt inside {REL_PERIPH, REL_CPU, RUN};
         CPU_RESET_N    <= state_nxt inside {REL_CPU, RUN};
         INIT_DONE      <= (state_nxt == RUN);
         if (state_nxt == ERROR) TIMEOUT_ERR <= 1'b1;
      end
   end

   assign STATE = state;

   release_order_a: assert property (@(posedge CLK) disable iff (RESET)
      (!CPU_RESET_N || PERIPH_RESET_N) && (!PERIPH_RESET_N || FABRIC_RESET_N));

   error_holds_resets_a: assert property (@(posedge CLK) disable iff (RESET)
      (state == ERROR) |-> (TIMEOUT_ERR && !FABRIC_RESET_N));

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Bench for init_reset_sequencer: two instances (SRAM required / not required) share randomized and directed stimulus.
// A timestamp-based reference model queues expected outputs per clock; a monitor pops and compares on the falling edge.
module tb_init_reset_sequencer;

   localparam int SYNC   = 2;
   localparam int SETTLE = 16;
   localparam int STAGE  = 8;
   localparam int TO     = 100;
   localparam int MAXC   = 12000;

   logic       clk = 1'b0;
   logic       rst;
   logic       por_n, dev_done, sram_done, usram_done, pll_lock, ext_rst_n;
   logic [1:0] fab_n, per_n, cpu_n, idone, terr;
   logic [2:0] st0, st1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   init_reset_sequencer #(
      .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .STAGE_DELAY(STAGE),
      .TIMEOUT_CYCLES(TO), .REQUIRE_SRAM(1'b1)
   ) u_dut0 (
      .CLK(clk), .RESET(rst), .FABRIC_POR_N(por_n), .DEVICE_INIT_DONE(dev_done),
      .SRAM_INIT_DONE(sram_done), .USRAM_INIT_DONE(usram_done), .PLL_LOCK(pll_lock),
      .EXT_RST_N(ext_rst_n), .FABRIC_RESET_N(fab_n[0]), .PERIPH_RESET_N(per_n[0]),
      .CPU_RESET_N(cpu_n[0]), .INIT_DONE(idone[0]), .TIMEOUT_ERR(terr[0]), .STATE(st0)
   );

   init_reset_sequencer #(
      .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .STAGE_DELAY(STAGE),
      .TIMEOUT_CYCLES(TO), .REQUIRE_SRAM(1'b0)
   ) u_dut1 (
      .CLK(clk), .RESET(rst), .FABRIC_POR_N(por_n), .DEVICE_INIT_DONE(dev_done),
      .SRAM_INIT_DONE(sram_done), .USRAM_INIT_DONE(usram_done), .PLL_LOCK(pll_lock),
      .EXT_RST_N(ext_rst_n), .FABRIC_RESET_N(fab_n[1]), .PERIPH_RESET_N(per_n[1]),
      .CPU_RESET_N(cpu_n[1]), .INIT_DONE(idone[1]), .TIMEOUT_ERR(terr[1]), .STATE(st1)
   );

   // ---------------- reference model ----------------
   int         cyc = 0;
   int         last_rst = 0;
   logic [5:0] raw_hist [MAXC];
   int         m_st [2];
   int         m_e [2];
   int         m_brk [2];
   int         m_held [2];
   logic       m_terr [2];
   logic [7:0] exp_q0 [$];
   logic [7:0] exp_q1 [$];

   function automatic logic [7:0] pack_exp(input int s, input logic t);
      logic [2:0] s3;
      s3 = 3'(s);
      return {s3, (s >= 3 && s <= 6), (s >= 4 && s <= 6), (s >= 5 && s <= 6), (s == 6), t};
   endfunction

   function automatic logic [7:0] dut_out(input int i);
      if (i == 0) return {st0, fab_n[0], per_n[0], cpu_n[0], idone[0], terr[0]};
      return {st1, fab_n[1], per_n[1], cpu_n[1], idone[1], terr[1]};
   endfunction

   task automatic model_step();
      logic [5:0] s;
      logic       por, dev, sram, usram, lock, ext, done;
      int         n, nx;
      cyc++;
      n = cyc;
      if (n >= MAXC) begin
         $display("FAIL model_range: cycle %0d reached limit %0d", n, MAXC);
         $fatal(1, "model history exhausted");
      end
      raw_hist[n] = rst ? 6'b0 : {por_n, dev_done, sram_done, usram_done, pll_lock, ext_rst_n};
      if (rst) last_rst = n;
      // A synchronized value is the raw input SYNC edges ago, unless a reset flushed the chain since.
      s = (n - SYNC <= last_rst) ? 6'b0 : raw_hist[n - SYNC];
      {por, dev, sram, usram, lock, ext} = s;
      for (int i = 0; i < 2; i++) begin
         nx   = m_st[i];
         done = dev && ((i == 1) || (sram && usram));
         if (rst) begin
            nx = 0;
            m_terr[i] = 1'b0;
         end else if (m_st[i] == 0) begin
            if (por) nx = 1;
         end else if (m_st[i] == 7) begin
            if (!por) nx = 0;
         end else if (!por) begin
            nx = 0;
         end else if (m_st[i] == 1) begin
            if (done) nx = 2;
            else if (n - m_e[i] >= TO) nx = 7;
         end else if (m_st[i] == 2) begin
            if (!ext) begin
               m_held[i]++;
               m_brk[i] = n;
            end else if (lock && n - m_brk[i] >= SETTLE) begin
               nx = 3;
            end else begin
               if (!lock) m_brk[i] = n;
               if (n - m_e[i] - 1 - m_held[i] == TO - 1) nx = 7;
            end
         end else if (!ext || !lock) begin
            nx = 2;
         end else if (m_st[i] < 6 && n - m_e[i] >= STAGE) begin
            nx = m_st[i] + 1;
         end
         if (rst || nx != m_st[i]) begin
            m_e[i]    = n;
            m_brk[i]  = n;
            m_held[i] = 0;
         end
         if (nx == 7) m_terr[i] = 1'b1;
         m_st[i] = nx;
         if (i == 0) exp_q0.push_back(pack_exp(nx, m_terr[i]));
         else        exp_q1.push_back(pack_exp(nx, m_terr[i]));
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_st[i] = 0; m_e[i] = 0; m_brk[i] = 0; m_held[i] = 0; m_terr[i] = 1'b0;
      end
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // ---------------- monitor ----------------
   task automatic compare_out(input int i, input logic [7:0] exp);
      logic [7:0] got;
      got = dut_out(i);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL outputs_dut%0d at cycle %0d: got state=%0d rst_n=%b done=%b terr=%b, required state=%0d rst_n=%b done=%b terr=%b",
                  i, cyc, got[7:5], got[4:2], got[1], got[0], exp[7:5], exp[4:2], exp[1], exp[0]);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (exp_q0.size() > 0) compare_out(0, exp_q0.pop_front());
         if (exp_q1.size() > 0) compare_out(1, exp_q1.pop_front());
      end
   end

   // ---------------- directed helpers ----------------
   task automatic check(input string name, input int got, input int exp);
      n_assert++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   function automatic int sig0(input int sel);
      case (sel)
         0:       return int'(fab_n[0]);
         1:       return int'(per_n[0]);
         2:       return int'(cpu_n[0]);
         3:       return int'(idone[0]);
         4:       return int'(st0);
         default: return int'(st1);
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Counts edges until the selected DUT0 signal reaches val; a budget overrun shows up as a wrong count.
   task automatic wait_for(input string name, input int sel, input int val, input int exp_k);
      int k;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (sig0(sel) != val && k < 400);
      check(name, k, exp_k);
   endtask

   function automatic logic keep_or_flip(input logic v, input logic good, input int p_bad);
      if (v == good) return ($urandom_range(0, p_bad - 1) == 0) ? ~good : good;
      return ($urandom_range(0, 3) == 0) ? good : v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      por_n = 1'b0; dev_done = 1'b0; sram_done = 1'b0; usram_done = 1'b0;
      pll_lock = 1'b0; ext_rst_n = 1'b1;
      tick(3);
      check("reset_state", int'(st0), 0);
      check("reset_outputs", int'({fab_n[0], per_n[0], cpu_n[0], idone[0], terr[0]}), 0);
      rst = 1'b0;

      // Normal bring-up
      por_n = 1'b1;
      tick(10);
      dev_done = 1'b1; sram_done = 1'b1; usram_done = 1'b1;
      tick(10);
      pll_lock = 1'b1;
      wait_for("fabric_release", 0, 1, SYNC + SETTLE);
      wait_for("periph_release", 1, 1, STAGE);
      wait_for("cpu_release",    2, 1, STAGE);
      wait_for("init_done",      3, 1, STAGE);
      check("run_state", int'(st0), 6);

      // Lock loss in RUN and relock
      pll_lock = 1'b0;
      wait_for("lockloss_fabric", 0, 0, SYNC + 1);
      check("lockloss_state", int'(st0), 2);
      check("lockloss_others", int'({per_n[0], cpu_n[0], idone[0]}), 0);
      tick(5);
      pll_lock = 1'b1;
      wait_for("relock_fabric", 0, 1, SYNC + SETTLE);
      wait_for("relock_run",    3, 1, 3 * STAGE);

      // Lock glitch during settle restarts the whole window
      pll_lock = 1'b0;
      wait_for("glitch_drop", 0, 0, SYNC + 1);
      tick(3);
      pll_lock = 1'b1;
      tick(10);
      pll_lock = 1'b0;
      tick(1);
      pll_lock = 1'b1;
      wait_for("glitch_resettle", 0, 1, SYNC + SETTLE);
      wait_for("glitch_run",      3, 1, 3 * STAGE);

      // POR loss beats external reset when both arrive in REL_PERIPH
      pll_lock = 1'b0;
      tick(4);
      pll_lock = 1'b1;
      wait_for("prio_fabric", 0, 1, SYNC + SETTLE);
      wait_for("prio_periph", 1, 1, STAGE);
      ext_rst_n = 1'b0;
      por_n     = 1'b0;
      wait_for("prio_state_por", 4, 0, SYNC + 1);

      // SRAM requirement and init timeout
      ext_rst_n = 1'b1; pll_lock = 1'b0; sram_done = 1'b0; usram_done = 1'b0;
      tick(2);
      por_n = 1'b1;
      tick(10);
      check("sram_required_holds", int'(st0), 1);
      check("sram_optional_exits", int'(st1), 2);
      wait_for("init_timeout", 4, 7, SYNC + 1 + TO - 10);
      check("timeout_flag", int'(terr[0]), 1);
      check("timeout_resets", int'({fab_n[0], per_n[0], cpu_n[0], idone[0]}), 0);
      por_n = 1'b0;
      wait_for("timeout_por_exit", 4, 0, SYNC + 1);
      check("timeout_flag_sticky", int'(terr[0]), 1);

      // Synchronous reset in the middle of the release sequence
      sram_done = 1'b1; usram_done = 1'b1; pll_lock = 1'b1; por_n = 1'b1;
      wait_for("mid_fabric", 0, 1, SYNC + 2 + SETTLE);
      tick(3);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midreset_state", int'(st0), 0);
      check("midreset_outputs", int'({fab_n[0], per_n[0], cpu_n[0], idone[0], terr[0]}), 0);
      check("midreset_state_dut1", int'(st1), 0);

      // Randomized phase against the model
      for (int c = 0; c < 2500; c++) begin
         por_n      = keep_or_flip(por_n, 1'b1, 400);
         dev_done   = keep_or_flip(dev_done, 1'b1, 300);
         sram_done  = keep_or_flip(sram_done, 1'b1, 300);
         usram_done = keep_or_flip(usram_done, 1'b1, 300);
         pll_lock   = keep_or_flip(pll_lock, 1'b1, 120);
         ext_rst_n  = keep_or_flip(ext_rst_n, 1'b1, 150);
         rst        = ($urandom_range(0, 799) == 0);
         tick(1);
      end
      rst = 1'b0;
      tick(5);
      @(negedge clk);
      #1;
      check("scoreboard_drain", exp_q0.size() + exp_q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
